// File: rtl/flag_branch_pkg.sv
// Shared types and constants for the flag/branch unit: B.cond codes,
// the redirect/squash sequencer states and NZCV bit positions.
package flag_branch_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0,
        NE = 4'h1,
        HS = 4'h2,
        LO = 4'h3,
        MI = 4'h4,
        PL = 4'h5,
        VS = 4'h6,
        VC = 4'h7,
        HI = 4'h8,
        LS = 4'h9,
        GE = 4'hA,
        LT = 4'hB,
        GT = 4'hC,
        LE = 4'hD,
        AL = 4'hE,
        NV = 4'hF
    } cond_e;

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        SQUASH
    } state_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/flag_branch_unit_cond_eval.sv
// Combinational B.cond evaluator: NZCV flags + 4-bit condition -> pass.
// Codes 1110 and 1111 both mean "always".
module cond_eval
    import flag_branch_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       pass
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Decode the condition code against the current flags
    always_comb begin
        pass = 1'b1;
        case (cond_e'(cond))
            EQ:      pass = z;
            NE:      pass = !z;
            HS:      pass = c;
            LO:      pass = !c;
            MI:      pass = n;
            PL:      pass = !n;
            VS:      pass = v;
            VC:      pass = !v;
            HI:      pass = c && !z;
            LS:      pass = !c || z;
            GE:      pass = (n == v);
            LT:      pass = (n != v);
            GT:      pass = !z && (n == v);
            LE:      pass = z || (n != v);
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// EX-stage flag/branch unit: holds NZCV, resolves CBZ and B.cond,
// issues a one-cycle registered fetch redirect and sequences the squash
// of wrong-path instructions.
// Optional feature: define FLAG_BRANCH_PERF_EN to add a saturating
// 16-bit taken-branch counter output (taken_count).
module flag_branch_unit
    import flag_branch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned SQUASH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic                  ex_set_flags,
    input  logic [DATA_WIDTH-1:0] ex_result,
    input  logic                  ex_zero,
    input  logic                  ex_carry,
    input  logic                  ex_overflow,
    input  logic                  ex_is_bcond,
    input  logic                  ex_is_cbz,
    input  logic [3:0]            ex_cond,
    input  logic [ADDR_WIDTH-1:0] ex_target,
    input  logic                  stall,
    output logic [3:0]            flags_o,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_target,
    output logic                  squash
`ifdef FLAG_BRANCH_PERF_EN
    ,
    output logic [15:0]           taken_count
`endif
);

    localparam int unsigned CNT_W = $clog2(SQUASH_CYCLES + 1);

    state_e           state;
    logic [CNT_W-1:0] squashCnt;
    logic             condPass;
    logic             accept;
    logic             taken;
    logic             unusedResultBits;

    // Only the sign bit of the result feeds the flags
    assign unusedResultBits = ^ex_result[DATA_WIDTH-2:0];

    cond_eval u_condEval (
        .flags (flags_o),
        .cond  (ex_cond),
        .pass  (condPass)
    );

    // Accept/taken decision; branches see the flags held at cycle start
    always_comb begin
        accept = ex_valid && !stall && (state == IDLE);
        taken  = accept && (ex_is_cbz ? ex_zero : (ex_is_bcond && condPass));
    end

    // Flag register and redirect/squash sequencer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            squashCnt       <= '0;
            flags_o         <= '0;
            redirect_valid  <= 1'b0;
            redirect_target <= '0;
            squash          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && ex_set_flags) begin
                        flags_o <= {ex_result[DATA_WIDTH-1], ex_zero, ex_carry, ex_overflow};
                    end
                    if (taken) begin
                        state           <= REDIRECT;
                        redirect_valid  <= 1'b1;
                        redirect_target <= ex_target;
                        squash          <= 1'b1;
                    end
                end
                REDIRECT: begin
                    // Never stretched by stall
                    state          <= SQUASH;
                    redirect_valid <= 1'b0;
                    squashCnt      <= CNT_W'(SQUASH_CYCLES);
                end
                SQUASH: begin
                    if (!stall) begin
                        squashCnt <= squashCnt - 1'b1;
                        if (squashCnt == CNT_W'(1)) begin
                            state  <= IDLE;
                            squash <= 1'b0;
                        end
                    end
                end
                default: begin
                    state          <= IDLE;
                    redirect_valid <= 1'b0;
                    squash         <= 1'b0;
                end
            endcase
        end
    end

`ifdef FLAG_BRANCH_PERF_EN
    // Saturating count of taken branches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            taken_count <= '0;
        end else if (taken && (taken_count != '1)) begin
            taken_count <= taken_count + 16'd1;
        end
    end
`endif

endmodule
